// File: rtl/maze_pkg.sv
// Shared maze geometry, FSM encoding and wall-bit index helpers.
// Used by maze_generator and scene_exhibitor.
package maze_pkg;

  localparam int ROWS = 15;
  localparam int COLS = 10;
  localparam int H_W  = (ROWS + 1) * COLS;
  localparam int V_W  = ROWS * (COLS + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CARVE,
    COMMIT
  } state_t;

  typedef logic [3:0] rc_t;

  // horizontal line r, column c
  function automatic logic [7:0] h_idx(
    input rc_t r,
    input rc_t c
  );
    return 8'(H_W - 1 - (int'(r) * COLS + int'(c)));
  endfunction

  // row r, vertical boundary c
  function automatic logic [7:0] v_idx(
    input rc_t r,
    input rc_t c
  );
    return 8'(V_W - 1 - (int'(r) * (COLS + 1) + int'(c)));
  endfunction

endpackage

// File: rtl/maze_generator_if.sv
// Request/result bundle between control FSM and maze_generator.
// The generator is the slave; the controller/bench is the master.
interface maze_generator_if;
  import maze_pkg::*;

  logic           start;
  logic [15:0]    seed;
  logic           busy;
  logic           valid;
  logic [H_W-1:0] h_walls;
  logic [V_W-1:0] v_walls;

  modport master (
    output start,
    output seed,
    input  busy,
    input  valid,
    input  h_walls,
    input  v_walls
  );

  modport slave (
    input  start,
    input  seed,
    output busy,
    output valid,
    output h_walls,
    output v_walls
  );

endinterface

// File: rtl/maze_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting left.
// A zero seed is replaced by DEFAULT_SEED so the LFSR never locks up.
module maze_lfsr #(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        shift_i,
  output logic        bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // load has priority over shift
  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 16'h0) ? DEFAULT_SEED : seed_i;
    end else if (shift_i) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/maze_generator.sv
// Binary-tree perfect-maze generator, one cell per clock.
// Built in working registers, copied to outputs in one commit cycle.
module maze_generator
  import maze_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  maze_generator_if.slave bus
);

  state_t         state_q, state_d;
  rc_t            r_q, r_d;
  rc_t            c_q, c_d;
  logic [H_W-1:0] wh_q, wh_d;
  logic [V_W-1:0] wv_q, wv_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;

  logic lfsr_bit;
  logic accept;
  logic top_row;
  logic right_col;
  logic last_cell;
  logic carve_n;
  logic carve_e;

  assign accept    = (state_q == IDLE) && bus.start;
  assign top_row   = (r_q == 4'd0);
  assign right_col = (c_q == 4'(COLS - 1));
  assign last_cell = (r_q == 4'(ROWS - 1)) && right_col;

  // top-right cell carves nothing; rows/cols on the edge are forced
  assign carve_n = !top_row && (right_col || lfsr_bit);
  assign carve_e = !right_col && (top_row || !lfsr_bit);

  maze_lfsr #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .seed_i (bus.seed),
    .shift_i(state_q == CARVE),
    .bit_o  (lfsr_bit)
  );

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.start) state_d = CLEAR;
      CLEAR:  state_d = CARVE;
      CARVE:  if (last_cell) state_d = COMMIT;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // counters, working walls and committed outputs
  always_comb begin
    r_d     = r_q;
    c_d     = c_q;
    wh_d    = wh_q;
    wv_d    = wv_q;
    h_d     = h_q;
    v_d     = v_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) busy_d = 1'b1;
      end
      CLEAR: begin
        wh_d = '1;
        wv_d = '1;
        r_d  = '0;
        c_d  = '0;
      end
      CARVE: begin
        if (carve_n) wh_d[h_idx(r_q, c_q)] = 1'b0;
        if (carve_e) wv_d[v_idx(r_q, rc_t'(c_q + 4'd1))] = 1'b0;
        if (right_col) begin
          c_d = '0;
          r_d = rc_t'(r_q + 4'd1);
        end else begin
          c_d = rc_t'(c_q + 4'd1);
        end
      end
      COMMIT: begin
        h_d     = wh_q;
        v_d     = wv_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // registers; reset leaves a fully closed grid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      wh_q    <= '1;
      wv_q    <= '1;
      h_q     <= '1;
      v_q     <= '1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      wh_q    <= wh_d;
      wv_q    <= wv_d;
      h_q     <= h_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.h_walls = h_q;
  assign bus.v_walls = v_q;

endmodule
